// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a carry flop, adding two WIDTH-bit operands LSB-first.
// Valid/ready on both sides, a single operation in flight.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_sr_nxt;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_carry;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;

  full_adder u_fa (
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .carry_in (c_reg),
    .sum      (fa_sum),
    .carry_out(fa_carry)
  );

  assign last_bit   = (cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; written as a shift/or so WIDTH=1 needs no special case.
  assign sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid)  next_state = ADD;
      ADD:     if (last_bit)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake/status outputs are registered, so they are decoded from next_state.
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    unique case (next_state)
      IDLE:    in_ready_nxt = 1'b1;
      ADD:     busy_nxt     = 1'b1;
      DONE: begin
        out_valid_nxt = 1'b1;
        busy_nxt      = 1'b1;
      end
      default: in_ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Datapath: load on accept, shift one bit per ADD cycle, capture result on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            c_reg <= carry_in;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_sr_nxt;
          c_reg  <= fa_carry;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum       <= sum_sr_nxt;
            carry_out <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
